load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit in the MEM stage. It sits directly upstream of the data memory and turns pipeline load/store requests (RV32 funct3 encodings, any byte alignment) into full-word read and write accesses on the memory port. Sub-word stores use read-modify-write, and accesses that cross a word boundary are split into two word accesses. It returns aligned, sign- or zero-extended load data with a valid pulse, and holds REQ_READY low while busy so the pipeline stalls.

## Interface
- INDEX_BITS, 10, memory word-index width; covers 4 KiB of byte addresses, indexed by address bits [INDEX_BITS+1:2].
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present; held stable by upstream until accepted.
- REQ_READY  out  1  high only in IDLE while RESET is low; a request is accepted at an edge where REQ_VALID and REQ_READY are both high.
- REQ_READ  in  1  load request.
- REQ_WRITE  in  1  store request.
- REQ_FUNC3  in  3  RV32 load/store funct3.
- REQ_ADDRESS  in  32  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_ERROR  out  1  qualified by RESP_VALID; the request was illegal.
- LOAD_DATA  out  32  qualified by RESP_VALID; 0 for stores and errors.
- MEM_ADDRESS  out  32  word-aligned: {0, index, 2'b00}.
- MEM_WRITE_DATA  out  32  full merged word.
- MEM_READ  out  1  memory read enable; memory read data is combinational.
- MEM_WRITE  out  1  memory write enable.
- MEM_FUNC3  out  3  always 3'b010 (full-word write).
- MEM_READ_DATA  in  32  memory read data.

## Operation
- On accept, latch op, funct3, address, wdata. Define: offset = addr[1:0]; size = 1/2/4 bytes for funct3[1:0] = 00/01/10; SPLIT = offset + size > 4; idx0 = addr[INDEX_BITS+1:2]; idx1 = idx0 + 1 mod 2^INDEX_BITS (1023 wraps to 0). Address bits above INDEX_BITS+1 are ignored.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010.
- Illegal requests: any other funct3, REQ_READ and REQ_WRITE both high, or both low. These go straight to RESP with RESP_ERROR=1 and make no memory access.
- FSM states: IDLE, READ0, READ1, WRITE0, WRITE1, RESP.
- IDLE to READ0 on a legal accept, except an aligned SW (offset 0, funct3 010), which goes to WRITE0 directly.
- READ0: MEM_READ=1 at idx0; capture W0 at the edge. Next state is READ1 if SPLIT, else RESP for a load or WRITE0 for a store.
- READ1: MEM_READ=1 at idx1; capture W1. Next state is RESP for a load, WRITE0 for a store.
- WRITE0: MEM_WRITE=1 at idx0 with merged W0. Next state is WRITE1 if SPLIT, else RESP.
- WRITE1: MEM_WRITE=1 at idx1 with merged W1. Next state is RESP.
- RESP: RESP_VALID=1. Next state is IDLE.
- Merge: treat {W1,W0} as 8 bytes. Byte k of REQ_WDATA (k < size) replaces byte offset+k; all other bytes are kept. For an aligned SW, W0 is REQ_WDATA.
- Load: take ({W1,W0} >> 8*offset)[8*size-1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- MEM_READ and MEM_WRITE are never high together. When idle, all MEM_* outputs are 0, except MEM_FUNC3, which is always 3'b010.

## Timing
- The accept edge is edge A. RESP_VALID is high during the cycle that starts at:
  - A+1: error.
  - A+2: aligned load; aligned SW.
  - A+3: split load; non-split sub-word store.
  - A+5: split store.
- REQ_READY returns high in the cycle after RESP, so back-to-back requests are spaced by the latency plus one cycle.
- Reset values:
  - State: IDLE.
  - REQ_READY, RESP_VALID, RESP_ERROR, LOAD_DATA, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA: all 0.
  - MEM_FUNC3: 3'b010.
- RESET asserted mid-operation: the FSM goes to IDLE immediately and MEM_WRITE drops asynchronously. No response is produced for the abandoned request.
- Reset between WRITE0 and WRITE1 of a split store leaves idx0 updated and idx1 untouched. This is accepted behaviour.
- REQ_* changes while busy are ignored. The latched copy is used throughout.

## Test plan
- Aligned word: SW 0x0000_0100 ← 0xDEADBEEF, then LW 0x100. Required: a single memory write at index 0x40; LOAD_DATA = 0xDEADBEEF with RESP_VALID at A+2.
- Byte and half extension: preload word 0x100 = 0x8081_7F80. Required:
  - LB 0x103 → 0xFFFFFF80.
  - LBU 0x101 → 0x0000007F.
  - LH 0x102 → 0xFFFF8081.
  - LHU 0x102 → 0x00008081.
- Sub-word RMW: preload 0x100 = 0x11223344. SB 0x102 ← 0xAA. Required: READ0 then WRITE0 with MEM_WRITE_DATA = 0x11AA3344; RESP at A+3.
- Split store and load: preload 0x100 = 0x11223344 and 0x104 = 0x55667788. SW 0x103 ← 0xA1B2C3D4. Required:
  - Words become 0xD4223344 and 0x55A1B2C3; RESP at A+5.
  - A subsequent LW 0x103 returns 0xA1B2C3D4 at A+3.
- Wrap: LH 0xFFF with word 0x3FF = 0x12xxxxxx and word 0 = 0xxxxxxx34. Required: the second access goes to index 0; LOAD_DATA = 0x00003412.
- Error and reset:
  - Funct3 011 load → RESP_ERROR=1 at A+1, no MEM_READ.
  - RESET pulsed during WRITE0 of a split store → MEM_WRITE drops immediately, REQ_READY is high after release, no RESP_VALID.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte-addressed RV32 loads and stores into
// full-word memory accesses, with read-modify-write for sub-word stores
// and two-access splitting for requests that straddle a word boundary.
module load_store_unit #(
    parameter int INDEX_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ0,
        READ1,
        WRITE0,
        WRITE1,
        RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    is_load_q;
    logic                    error_q;
    logic [2:0]              func3_q;
    logic [1:0]              offset_q;
    logic [INDEX_BITS-1:0]   idx0_q;
    logic [INDEX_BITS-1:0]   idx1;
    logic [31:0]             wdata_q;
    logic [31:0]             w0_q;
    logic [31:0]             w1_q;
    logic [2:0]              size;
    logic                    split;
    logic                    accept;
    logic                    req_legal;
    logic                    req_aligned_sw;
    logic [63:0]             merged;
    logic [63:0]             window;
    logic [31:0]             extended;

    assign accept    = req_valid && req_ready;
    assign idx1      = idx0_q + {{(INDEX_BITS-1){1'b0}}, 1'b1};
    assign split     = ({1'b0, offset_q} + size) > 3'd4;
    assign mem_func3 = 3'b010;
    assign req_aligned_sw = req_write && (req_func3 == 3'b010) && (req_address[1:0] == 2'b00);

    // Decide whether the incoming request is a legal load or store
    always_comb begin
        req_legal = 1'b0;
        if (req_read && !req_write) begin
            case (req_func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end else if (req_write && !req_read) begin
            case (req_func3)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                default:                req_legal = 1'b0;
            endcase
        end
    end

    // Access size in bytes from the latched funct3
    always_comb begin
        case (func3_q[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Latch the request on accept and capture memory words as they are read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_load_q <= 1'b0;
            error_q   <= 1'b0;
            func3_q   <= 3'b000;
            offset_q  <= 2'b00;
            idx0_q    <= '0;
            wdata_q   <= 32'h0;
            w0_q      <= 32'h0;
            w1_q      <= 32'h0;
        end else begin
            if (accept) begin
                is_load_q <= req_read;
                error_q   <= !req_legal;
                func3_q   <= req_func3;
                offset_q  <= req_address[1:0];
                idx0_q    <= req_address[INDEX_BITS+1:2];
                wdata_q   <= req_wdata;
            end
            if (state == READ0) w0_q <= mem_read_data;
            if (state == READ1) w1_q <= mem_read_data;
        end
    end

    // Next-state sequencing through the read and write phases
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_legal)          next_state = RESP;
                    else if (req_aligned_sw) next_state = WRITE0;
                    else                     next_state = READ0;
                end
            end
            READ0:   next_state = split ? READ1 : (is_load_q ? RESP : WRITE0);
            READ1:   next_state = is_load_q ? RESP : WRITE0;
            WRITE0:  next_state = split ? WRITE1 : RESP;
            WRITE1:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Overlay the store bytes onto the two-word window read from memory
    always_comb begin
        merged = {w1_q, w0_q};
        for (int k = 0; k < 4; k++) begin
            if (k < int'(size)) merged[8*(int'(offset_q)+k) +: 8] = wdata_q[8*k +: 8];
        end
    end

    // Align the loaded bytes and apply sign or zero extension
    always_comb begin
        window = {w1_q, w0_q} >> {offset_q, 3'b000};
        case (func3_q)
            3'b000:  extended = {{24{window[7]}}, window[7:0]};
            3'b001:  extended = {{16{window[15]}}, window[15:0]};
            3'b100:  extended = {24'h0, window[7:0]};
            3'b101:  extended = {16'h0, window[15:0]};
            default: extended = window[31:0];
        endcase
    end

    // Drive the memory port and response outputs from the current state
    always_comb begin
        req_ready      = (state == IDLE) && !reset;
        resp_valid     = 1'b0;
        resp_error     = 1'b0;
        load_data      = 32'h0;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        case (state)
            READ0: begin
                mem_read    = 1'b1;
                mem_address = {{(30-INDEX_BITS){1'b0}}, idx0_q, 2'b00};
            end
            READ1: begin
                mem_read    = 1'b1;
                mem_address = {{(30-INDEX_BITS){1'b0}}, idx1, 2'b00};
            end
            WRITE0: begin
                mem_write      = 1'b1;
                mem_address    = {{(30-INDEX_BITS){1'b0}}, idx0_q, 2'b00};
                mem_write_data = merged[31:0];
            end
            WRITE1: begin
                mem_write      = 1'b1;
                mem_address    = {{(30-INDEX_BITS){1'b0}}, idx1, 2'b00};
                mem_write_data = merged[63:32];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = error_q;
                load_data  = (is_load_q && !error_q) ? extended : 32'h0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] load_data;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          excl_viol = 0;

    load_store_unit #(.INDEX_BITS(10)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_read(req_read),
        .req_write(req_write),
        .req_func3(req_func3),
        .req_address(req_address),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_error(resp_error),
        .load_data(load_data),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_func3(mem_func3),
        .mem_read_data(mem_read_data)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to measure response latency
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read memory model
    assign mem_read_data = mem[mem_address[11:2]];

    // Commit writes and log every memory access
    always @(posedge clk) begin
        if (!reset) begin
            if (mem_write) begin
                mem[mem_address[11:2]] = mem_write_data;
                wr_addr_log.push_back(mem_address);
                wr_data_log.push_back(mem_write_data);
            end
            if (mem_read) rd_log.push_back(mem_address);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: compare each response against the oldest expectation
    always @(negedge clk) begin
        if (mem_read && mem_write) excl_viol++;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("load_data", load_data, e.data);
                check_output("resp_error", {31'h0, resp_error}, {31'h0, e.err});
                check_output("latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic apply_stimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_data, input bit exp_err,
                                  input int exp_lat, input bit expect_resp);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check_output("ready_timeout", 32'd0, 32'd1);
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        req_valid   = 1'b1;
        req_read    = rd;
        req_write   = wr;
        req_func3   = f3;
        req_address = addr;
        req_wdata   = wdata;
        @(posedge clk);
        #1;
        if (expect_resp) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.lat  = exp_lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid   = 1'b0;
        req_address = 32'hFFFF_FFFF;
        req_wdata   = 32'h0;
        req_func3   = 3'b111;
        if (expect_resp) begin
            guard = 0;
            #1;
            while (sb.size() != 0 && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (sb.size() != 0) begin
                check_output("resp_timeout", 32'd0, 32'd1);
                sb.delete();
            end
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int guard;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        #3;
        check_output("rst_ready", {31'h0, req_ready}, 32'd0);
        check_output("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check_output("rst_mem_ctl", {30'h0, mem_read, mem_write}, 32'd0);
        check_output("rst_mem_addr", mem_address, 32'h0);
        check_output("rst_mem_wdata", mem_write_data, 32'h0);
        check_output("rst_load_data", load_data, 32'h0);
        check_output("rst_func3", {29'h0, mem_func3}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("ready_after_rst", {31'h0, req_ready}, 32'd1);

        // Aligned word store then load
        apply_stimulus(0, 1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0, 0, 2, 1);
        check_output("sw_write_count", wr_addr_log.size(), 32'd1);
        check_output("sw_read_count", rd_log.size(), 32'd0);
        if (wr_addr_log.size() > 0) check_output("sw_write_addr", wr_addr_log[0], 32'h100);
        check_output("sw_mem", mem[10'h40], 32'hDEADBEEF);
        apply_stimulus(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 2, 1);

        // Byte and half extension
        mem[10'h40] = 32'h8081_7F80;
        apply_stimulus(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 0, 2, 1);
        apply_stimulus(1, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_007F, 0, 2, 1);
        apply_stimulus(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'hFFFF_8081, 0, 2, 1);
        apply_stimulus(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h0000_8081, 0, 2, 1);

        // Sub-word read-modify-write; upper wdata bytes must be ignored
        mem[10'h40] = 32'h1122_3344;
        apply_stimulus(0, 1, 3'b000, 32'h0000_0102, 32'hFFFF_FFAA, 32'h0, 0, 3, 1);
        check_output("sb_read_count", rd_log.size(), 32'd1);
        check_output("sb_write_count", wr_addr_log.size(), 32'd1);
        if (wr_data_log.size() > 0) check_output("sb_write_data", wr_data_log[0], 32'h11AA_3344);

        // Split store then split load
        mem[10'h40] = 32'h1122_3344;
        mem[10'h41] = 32'h5566_7788;
        apply_stimulus(0, 1, 3'b010, 32'h0000_0103, 32'hA1B2_C3D4, 32'h0, 0, 5, 1);
        check_output("split_w0", mem[10'h40], 32'hD422_3344);
        check_output("split_w1", mem[10'h41], 32'h55A1_B2C3);
        apply_stimulus(1, 0, 3'b010, 32'h0000_0103, 32'h0, 32'hA1B2_C3D4, 0, 3, 1);

        // Index wrap from the last word to word 0
        mem[10'h3FF] = 32'h12AB_CDEF;
        mem[10'h000] = 32'h9988_7734;
        apply_stimulus(1, 0, 3'b001, 32'h0000_0FFF, 32'h0, 32'h0000_3412, 0, 3, 1);
        check_output("wrap_read_count", rd_log.size(), 32'd2);
        if (rd_log.size() > 1) check_output("wrap_second_addr", rd_log[1], 32'h0);

        // Illegal requests
        apply_stimulus(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1, 1, 1);
        check_output("err_no_read", rd_log.size(), 32'd0);
        apply_stimulus(1, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 1, 1, 1);
        apply_stimulus(0, 1, 3'b100, 32'h0000_0100, 32'h1234_5678, 32'h0, 1, 1, 1);
        check_output("err_no_write", wr_addr_log.size(), 32'd0);

        // Reset pulsed during the first write of a split store
        mem[10'h40] = 32'h1122_3344;
        mem[10'h41] = 32'h5566_7788;
        apply_stimulus(0, 1, 3'b010, 32'h0000_0103, 32'hA1B2_C3D4, 32'h0, 0, 0, 0);
        guard = 0;
        while (!mem_write && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check_output("rst_test_reached_write", {31'h0, mem_write}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_output("mem_write_async_drop", {31'h0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("ready_after_midrst", {31'h0, req_ready}, 32'd1);
        repeat (8) @(negedge clk);

        check_output("mem_excl", excl_viol, 32'd0);
        check_output("func3_const", {29'h0, mem_func3}, 32'd2);
        check_output("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
